// File: rtl/seg7_capture_encoder_if.sv
// Display-bus observation plus frame handshake for the 7-segment capture encoder.
// The slave side is the encoder. The master side drives the display lines and consumes the frames.
interface seg7_capture_encoder_if #(
    parameter int DIGITS = 2
);
    logic [7:0]          seg_n;
    logic [DIGITS-1:0]   an_n;
    logic                out_ready;
    logic                out_valid;
    logic [4*DIGITS-1:0] out_bcd;
    logic [DIGITS-1:0]   out_err;
    logic                overrun;

    modport slave (
        input  seg_n, an_n, out_ready,
        output out_valid, out_bcd, out_err, overrun
    );

    modport master (
        output seg_n, an_n, out_ready,
        input  out_valid, out_bcd, out_err, overrun
    );
endinterface

// File: rtl/seg7_capture_encoder.sv
// Encodes a multiplexed active-low 7-seg bus back to BCD frames. A glyph is captured STABLE_CYCLES after its first sample, and the frame is valid one cycle later.
// A held frame blocks a newer complete frame: the newer frame is dropped and overrun pulses for one cycle.
module seg7_capture_encoder #(
    parameter int DIGITS        = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_capture_encoder_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, DWELL, HELD} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [6:0]              s_seg_q, p_seg_q;
    logic [DIGITS-1:0]       s_an_q, p_an_q;
    logic [DIGITS-1:0][3:0]  digit_q, digit_d;
    logic [DIGITS-1:0]       dig_err_q, dig_err_d;
    logic [DIGITS-1:0]       seen_q, seen_d;
    logic                    out_valid_q, out_valid_d;
    logic [4*DIGITS-1:0]     out_bcd_q, out_bcd_d;
    logic [DIGITS-1:0]       out_err_q, out_err_d;
    logic                    overrun_q, overrun_d;

    logic [3:0]              glyph_nib;
    logic                    glyph_err;
    logic                    sel_ok;
    logic [IW-1:0]           sel_idx;
    logic                    changed;
    logic                    capture;
    logic                    frame_done;
    logic                    unused_dot;

    // The decimal point is never part of a glyph, including for change detection.
    assign unused_dot = bus.seg_n[7];

    always_comb begin
        glyph_nib = 4'hF;
        glyph_err = 1'b0;
        unique case (s_seg_q)
            7'h40: glyph_nib = 4'd0;
            7'h79: glyph_nib = 4'd1;
            7'h24: glyph_nib = 4'd2;
            7'h30: glyph_nib = 4'd3;
            7'h19: glyph_nib = 4'd4;
            7'h12: glyph_nib = 4'd5;
            7'h02: glyph_nib = 4'd6;
            7'h78: glyph_nib = 4'd7;
            7'h00: glyph_nib = 4'd8;
            7'h10: glyph_nib = 4'd9;
            default: glyph_err = 1'b1;
        endcase
    end

    always_comb begin
        int nz;
        nz      = 0;
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!s_an_q[i]) begin
                nz      = nz + 1;
                sel_idx = IW'(i);
            end
        end
        sel_ok = (nz == 1);
    end

    assign changed = (s_seg_q != p_seg_q) || (s_an_q != p_an_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sel_ok) begin
                    state_d = DWELL;
                    cnt_d   = CW'(1);
                end
            end
            DWELL: begin
                if (!sel_ok) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (changed) begin
                    cnt_d = CW'(1);
                end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                    capture = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!sel_ok) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (changed) begin
                    state_d = DWELL;
                    cnt_d   = CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Completion is judged on the registered seen mask, one cycle after the last capture.
    assign frame_done = &seen_q;

    always_comb begin
        digit_d     = digit_q;
        dig_err_d   = dig_err_q;
        seen_d      = frame_done ? '0 : seen_q;
        out_valid_d = out_valid_q;
        out_bcd_d   = out_bcd_q;
        out_err_d   = out_err_q;
        overrun_d   = 1'b0;
        if (capture) begin
            digit_d[sel_idx]   = glyph_nib;
            dig_err_d[sel_idx] = glyph_err;
            seen_d[sel_idx]    = 1'b1;
        end
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (frame_done) begin
            if (!out_valid_q || bus.out_ready) begin
                out_valid_d = 1'b1;
                out_bcd_d   = digit_q;
                out_err_d   = dig_err_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            s_seg_q     <= '1;
            p_seg_q     <= '1;
            s_an_q      <= '1;
            p_an_q      <= '1;
            digit_q     <= '0;
            dig_err_q   <= '0;
            seen_q      <= '0;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
            out_err_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_seg_q     <= bus.seg_n[6:0];
            p_seg_q     <= s_seg_q;
            s_an_q      <= bus.an_n;
            p_an_q      <= s_an_q;
            digit_q     <= digit_d;
            dig_err_q   <= dig_err_d;
            seen_q      <= seen_d;
            out_valid_q <= out_valid_d;
            out_bcd_q   <= out_bcd_d;
            out_err_q   <= out_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_bcd   = out_bcd_q;
    assign bus.out_err   = out_err_q;
    assign bus.overrun   = overrun_q;
endmodule
